// File: rtl/rect_stream_tx.sv
// Output stage of the rectification pipeline: buffers the interpolator's valid-only
// pixel stream and re-emits it as an AXI4-Stream video master (tuser = SOF, tlast = EOL).
module rect_stream_tx #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              din_last,
    input  logic [DATA_W-1:0] din_data,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic              frame_err,
    output logic              frame_done
);

    localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W     = $clog2(FRAME_PIX);
    localparam int COL_W     = $clog2(IMG_WIDTH);
    localparam int ROW_W     = $clog2(IMG_HEIGHT);
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_nxt;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   level_nxt;
    logic [DATA_W-1:0] head_nxt;
    logic [DATA_W-1:0] tdata_r;
    logic              tvalid_r;
    logic              push;
    logic              pop;

    logic [CNT_W-1:0]  in_cnt;
    logic              in_last_idx;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              at_eol;
    logic              at_eof;

    assign pop  = tvalid_r & m_tready;
    assign push = din_valid & ((level != LEVEL_FULL) | pop);

    // The output register always holds the current head; when the FIFO drains to
    // empty in the same cycle as a push, the incoming pixel becomes the head directly.
    always_comb begin
        rd_nxt    = rd_ptr + ADDR_W'(pop);
        level_nxt = level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        head_nxt  = mem[rd_nxt];
        if (push && (level == (ADDR_W+1)'(pop)))
            head_nxt = din_data;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            rd_ptr   <= rd_nxt;
            level    <= level_nxt;
            tvalid_r <= (level_nxt != '0);
            if (level_nxt != '0)
                tdata_r <= head_nxt;
        end
    end

    assign in_last_idx = (in_cnt == CNT_W'(FRAME_PIX - 1));

    // Input counter resynchronises on whichever comes first: din_last or the frame size.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt    <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (din_valid && !push)
                overflow <= 1'b1;
            if (push) begin
                if (din_last != in_last_idx)
                    frame_err <= 1'b1;
                if (din_last || in_last_idx)
                    in_cnt <= '0;
                else
                    in_cnt <= in_cnt + CNT_W'(1);
            end
        end
    end

    assign at_eol = (col == COL_W'(IMG_WIDTH - 1));
    assign at_eof = at_eol && (row == ROW_W'(IMG_HEIGHT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && at_eof;
            if (pop) begin
                if (at_eol) begin
                    col <= '0;
                    row <= at_eof ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    assign m_tdata    = tdata_r;
    assign m_tvalid   = tvalid_r;
    assign m_tuser    = tvalid_r && (col == '0) && (row == '0);
    assign m_tlast    = tvalid_r && at_eol;
    assign fifo_level = level;

endmodule

// File: tb/tb_rect_stream_tx.sv
// Directed bench for rect_stream_tx using a reduced 16x8 frame and a 64-entry FIFO.
module tb_rect_stream_tx;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int PIX = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic       din_last = 1'b0;
    logic [7:0] din_data = 8'd0;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic       m_tlast;
    logic       m_tuser;
    logic [6:0] fifo_level;
    logic       overflow;
    logic       frame_err;
    logic       frame_done;

    rect_stream_tx #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (8),
        .FIFO_DEPTH(64),
        .ADDR_W    (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_data  (din_data),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .frame_err (frame_err),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] obs_data[$];
    bit         obs_user[$];
    bit         obs_last[$];
    int         obs_cyc[$];
    int         done_cnt;
    int         done_cyc;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                obs_data.push_back(m_tdata);
                obs_user.push_back(m_tuser);
                obs_last.push_back(m_tlast);
                obs_cyc.push_back(cyc);
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_user.delete();
        obs_last.delete();
        obs_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        din_last  = 1'b0;
        m_tready  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_obs();
    endtask

    task automatic push_px(input logic [7:0] d, input bit last);
        din_valid = 1'b1;
        din_data  = d;
        din_last  = last;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clear_obs();
        #1;
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_tdata", 32'(m_tdata), 0);
        check("rst_tuser", 32'(m_tuser), 0);
        check("rst_tlast", 32'(m_tlast), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_flags", 32'({overflow, frame_err, frame_done}), 0);

        // Full frame with continuous ready
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < PIX; i++) push_px(8'(i), i == PIX - 1);
        idle(5);
        check("ff_beats", 32'(obs_data.size()), PIX);
        for (int k = 0; k < obs_data.size(); k++) begin
            check("ff_data", 32'(obs_data[k]), 32'(k % 256));
            check("ff_user", 32'(obs_user[k]), 32'(k == 0));
            check("ff_last", 32'(obs_last[k]), 32'((k % W) == W - 1));
        end
        check("ff_done_cnt", 32'(done_cnt), 1);
        if (obs_cyc.size() == PIX) begin
            check("ff_done_cyc", 32'(done_cyc), 32'(obs_cyc[PIX-1] + 1));
            check("ff_no_bubble", 32'(obs_cyc[PIX-1] - obs_cyc[0]), PIX - 1);
        end
        check("ff_overflow", 32'(overflow), 0);
        check("ff_frame_err", 32'(frame_err), 0);
        check("ff_level", 32'(fifo_level), 0);

        // Backpressure: 40 pixels queued while stalled
        do_reset();
        for (int i = 0; i < 40; i++) push_px(8'(100 + i), 1'b0);
        idle(1);
        check("bp_level", 32'(fifo_level), 40);
        check("bp_tvalid", 32'(m_tvalid), 1);
        check("bp_tdata_hold", 32'(m_tdata), 100);
        check("bp_tuser_hold", 32'(m_tuser), 1);
        check("bp_no_beats", 32'(obs_data.size()), 0);
        m_tready = 1'b1;
        idle(45);
        check("bp_beats", 32'(obs_data.size()), 40);
        for (int k = 0; k < obs_data.size(); k++)
            check("bp_data", 32'(obs_data[k]), 32'(100 + k));
        if (obs_cyc.size() == 40)
            check("bp_consecutive", 32'(obs_cyc[39] - obs_cyc[0]), 39);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 64; i++) push_px(8'(i), 1'b0);
        check("fs_level_full", 32'(fifo_level), 64);
        check("fs_no_ovf_yet", 32'(overflow), 0);
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_px(8'(200 + i), 1'b0);
            check("fs_level_hold", 32'(fifo_level), 64);
        end
        idle(80);
        check("fs_overflow", 32'(overflow), 0);
        check("fs_beats", 32'(obs_data.size()), 74);
        for (int k = 0; k < obs_data.size(); k++)
            check("fs_data", 32'(obs_data[k]), (k < 64) ? 32'(k) : 32'(200 + k - 64));

        // Overflow: 70 pixels into a stalled 64-entry FIFO
        do_reset();
        for (int i = 0; i < 70; i++) push_px(8'(i), 1'b0);
        check("ov_level", 32'(fifo_level), 64);
        check("ov_flag", 32'(overflow), 1);
        m_tready = 1'b1;
        idle(70);
        check("ov_beats", 32'(obs_data.size()), 64);
        for (int k = 0; k < obs_data.size(); k++)
            check("ov_data", 32'(obs_data[k]), 32'(k));
        check("ov_sticky", 32'(overflow), 1);
        check("ov_level_empty", 32'(fifo_level), 0);

        // Framing error: early din_last, then a correct frame
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 50; i++) push_px(8'(i), 1'b0);
        check("fe_before", 32'(frame_err), 0);
        push_px(8'(50), 1'b1);
        check("fe_early_last", 32'(frame_err), 1);
        for (int i = 0; i < PIX; i++) push_px(8'(i), i == PIX - 1);
        check("fe_sticky", 32'(frame_err), 1);

        // Framing error: frame size reached without din_last
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < PIX - 1; i++) push_px(8'(i), 1'b0);
        check("fe_size_before", 32'(frame_err), 0);
        push_px(8'(PIX - 1), 1'b0);
        check("fe_missing_last", 32'(frame_err), 1);

        // Mid-frame reset during row 5
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 86; i++) push_px(8'(i), 1'b0);
        check("mr_tvalid_before", 32'(m_tvalid), 1);
        rst = 1'b1;
        #1;
        check("mr_tvalid_async", 32'(m_tvalid), 0);
        check("mr_level_async", 32'(fifo_level), 0);
        check("mr_tdata_async", 32'(m_tdata), 0);
        check("mr_marks_async", 32'({m_tuser, m_tlast}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_obs();
        check("mr_level_release", 32'(fifo_level), 0);
        for (int i = 0; i < PIX; i++) push_px(8'(50 + i), i == PIX - 1);
        idle(5);
        check("mr_beats", 32'(obs_data.size()), PIX);
        if (obs_data.size() > 0) begin
            check("mr_first_user", 32'(obs_user[0]), 1);
            check("mr_first_data", 32'(obs_data[0]), 50);
        end
        check("mr_frame_err", 32'(frame_err), 0);
        check("mr_done_cnt", 32'(done_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
